// File: rtl/m00_rd_arbiter_pkg.sv
// Shared types and widths for the m00 read arbiter: the AR payload carried
// toward the exit pipeline, the route entry that steers R beats back to the
// requesting port, and the round-robin pick helper.
package m00_rd_arb_pkg;

    localparam int ADDR_W  = 33;
    localparam int DATA_W  = 256;
    localparam int ID_W    = 3;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int QOS_W   = 4;
    localparam int RESP_W  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [CACHE_W-1:0] cache;
        logic [PROT_W-1:0]  prot;
        logic [QOS_W-1:0]   qos;
    } ar_pld_t;

    typedef struct packed {
        logic            port;
        logic [ID_W-1:0] id;
    } route_t;

    // Two-way round robin: on contention the port not granted last wins,
    // otherwise the lone requester wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
        logic pick;
        if (req == 2'b11) pick = ~last_gnt;
        else              pick = req[1];
        return pick;
    endfunction

endpackage

// File: rtl/m00_rd_arbiter_if.sv
// AXI4 read-channel bundles for the m00 read arbiter.
// m00_rd_arbiter_s_if: an upstream port (carries AR id and R id).
// m00_rd_arbiter_m_if: the shared downstream port (no id on either channel).
interface m00_rd_arbiter_s_if;
    import m00_rd_arb_pkg::*;

    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic [CACHE_W-1:0] arcache;
    logic [PROT_W-1:0]  arprot;
    logic [QOS_W-1:0]   arqos;
    logic [ID_W-1:0]    arid;
    logic               arvalid;
    logic               arready;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic [ID_W-1:0]    rid;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arqos, arid, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready
    );

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arqos, arid, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready
    );
endinterface

interface m00_rd_arbiter_m_if;
    import m00_rd_arb_pkg::*;

    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic [CACHE_W-1:0] arcache;
    logic [PROT_W-1:0]  arprot;
    logic [QOS_W-1:0]   arqos;
    logic               arvalid;
    logic               arready;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/m00_rd_arbiter_route_fifo.sv
// Route FIFO: remembers {port, id} for every granted read burst so R beats
// can be steered back in issue order. Registered count, wrap-around pointers,
// no pass-through (a push into a full FIFO is ignored even with a pop).
module m00_rd_route_fifo
    import m00_rd_arb_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic   aclk,
    input  logic   aresetn,
    input  logic   push,
    input  route_t wdata,
    input  logic   pop,
    output route_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    route_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Entry storage holds data only, so it carries no reset.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; reset empties the FIFO and drops in-flight routes.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/m00_rd_arbiter.sv
// m00 read arbiter: merges two AXI4 read ports onto the shared m00 read path.
// AR: round-robin grant into a 1-deep output register. R: beats steered to the
// port at the head of the route FIFO, popped on the last beat of each burst.
// Build option: define M00_RD_ARB_QOS_EN to let the higher arqos win, with
// round robin breaking equal-qos ties; undefined gives pure round robin.
module m00_rd_arbiter
    import m00_rd_arb_pkg::*;
#(
    parameter int ROUTE_DEPTH = 8
)
(
    input  logic               aclk,
    input  logic               aresetn,
    m00_rd_arbiter_s_if.slave  s0_axi,
    m00_rd_arbiter_s_if.slave  s1_axi,
    m00_rd_arbiter_m_if.master m_axi
);

    ar_pld_t    s0_pld;
    ar_pld_t    s1_pld;
    ar_pld_t    gnt_pld;
    ar_pld_t    ar_pld_p1;
    logic       ar_vld_p1;
    logic       last_gnt;
    logic [1:0] req;
    logic       arb_en;
    logic       gnt_vld;
    logic       gnt_port;
    route_t     push_entry;
    route_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       r_active;

    assign s0_pld = '{addr: s0_axi.araddr, len: s0_axi.arlen, size: s0_axi.arsize,
                      burst: s0_axi.arburst, cache: s0_axi.arcache,
                      prot: s0_axi.arprot, qos: s0_axi.arqos};
    assign s1_pld = '{addr: s1_axi.araddr, len: s1_axi.arlen, size: s1_axi.arsize,
                      burst: s1_axi.arburst, cache: s1_axi.arcache,
                      prot: s1_axi.arprot, qos: s1_axi.arqos};

    // Grant selection: arbitrate only when the output register can take a new
    // request and the route FIFO has room (registered full, so no pass-through).
    always_comb begin
        req      = {s1_axi.arvalid, s0_axi.arvalid};
        arb_en   = aresetn & (~ar_vld_p1 | m_axi.arready) & ~fifo_full;
        gnt_port = rr_pick(req, last_gnt);
`ifdef M00_RD_ARB_QOS_EN
        if (req == 2'b11 && s0_axi.arqos != s1_axi.arqos)
            gnt_port = (s1_axi.arqos > s0_axi.arqos);
`endif
        gnt_vld    = arb_en & (|req);
        gnt_pld    = gnt_port ? s1_pld : s0_pld;
        push_entry = '{port: gnt_port, id: (gnt_port ? s1_axi.arid : s0_axi.arid)};
    end

    assign s0_axi.arready = gnt_vld & ~gnt_port;
    assign s1_axi.arready = gnt_vld &  gnt_port;

    // ---- p1: AR output register ----
    // Load on grant, hold until the exit pipeline accepts; remember the winner.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ar_vld_p1 <= 1'b0;
            ar_pld_p1 <= '0;
            last_gnt  <= 1'b1;
        end else if (gnt_vld) begin
            ar_vld_p1 <= 1'b1;
            ar_pld_p1 <= gnt_pld;
            last_gnt  <= gnt_port;
        end else if (m_axi.arready) begin
            ar_vld_p1 <= 1'b0;
        end
    end

    assign m_axi.arvalid = ar_vld_p1;
    assign m_axi.araddr  = ar_pld_p1.addr;
    assign m_axi.arlen   = ar_pld_p1.len;
    assign m_axi.arsize  = ar_pld_p1.size;
    assign m_axi.arburst = ar_pld_p1.burst;
    assign m_axi.arcache = ar_pld_p1.cache;
    assign m_axi.arprot  = ar_pld_p1.prot;
    assign m_axi.arqos   = ar_pld_p1.qos;

    m00_rd_route_fifo #(
        .DEPTH (ROUTE_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (gnt_vld),
        .wdata   (push_entry),
        .pop     (fifo_pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---- R return: steer beats to the head route; stall while no route exists ----
    assign r_active      = aresetn & ~fifo_empty;
    assign m_axi.rready  = r_active & (head.port ? s1_axi.rready : s0_axi.rready);
    assign s0_axi.rvalid = r_active & m_axi.rvalid & ~head.port;
    assign s1_axi.rvalid = r_active & m_axi.rvalid &  head.port;
    assign fifo_pop      = m_axi.rvalid & m_axi.rready & m_axi.rlast;

    assign s0_axi.rdata  = m_axi.rdata;
    assign s0_axi.rresp  = m_axi.rresp;
    assign s0_axi.rlast  = m_axi.rlast;
    assign s0_axi.rid    = head.id;
    assign s1_axi.rdata  = m_axi.rdata;
    assign s1_axi.rresp  = m_axi.rresp;
    assign s1_axi.rlast  = m_axi.rlast;
    assign s1_axi.rid    = head.id;

endmodule

// File: tb/tb_m00_rd_arbiter.sv
// Bench for m00_rd_arbiter: scoreboard of accepted ARs and their routes,
// checked against the shared AR output and the per-port R returns.
module tb_m00_rd_arbiter;
    import m00_rd_arb_pkg::*;

    localparam int ROUTE_DEPTH = 8;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    m00_rd_arbiter_s_if s0_axi ();
    m00_rd_arbiter_s_if s1_axi ();
    m00_rd_arbiter_m_if m_axi ();

    m00_rd_arbiter #(
        .ROUTE_DEPTH (ROUTE_DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0_axi  (s0_axi),
        .s1_axi  (s1_axi),
        .m_axi   (m_axi)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt [2];
    int beat_seq = 0;

    logic [ADDR_W+LEN_W-1:0] ar_q   [$];
    route_t                  route_q[$];
    logic [DATA_W-1:0]       rdat_q [$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] next_data();
        beat_seq++;
        return {8{32'hA500_0000 + 32'(beat_seq)}};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        route_t            e;
        logic [DATA_W-1:0] d;
        if (aresetn) begin
            if (m_axi.rvalid && route_q.size() == 0)
                check("r_no_route_rready", 256'(m_axi.rready), 256'(0));
            if (m_axi.rvalid && m_axi.rready) begin
                if (route_q.size() == 0 || rdat_q.size() == 0) begin
                    check("r_sb_empty", 256'(1), 256'(0));
                end else begin
                    e = route_q[0];
                    d = rdat_q.pop_front();
                    rx_cnt[e.port]++;
                    if (e.port) begin
                        check("r_s1_rvalid", 256'(s1_axi.rvalid), 256'(1));
                        check("r_s1_rid",    256'(s1_axi.rid),    256'(e.id));
                        check("r_s1_rdata",  s1_axi.rdata,        d);
                        check("r_s0_quiet",  256'(s0_axi.rvalid), 256'(0));
                    end else begin
                        check("r_s0_rvalid", 256'(s0_axi.rvalid), 256'(1));
                        check("r_s0_rid",    256'(s0_axi.rid),    256'(e.id));
                        check("r_s0_rdata",  s0_axi.rdata,        d);
                        check("r_s1_quiet",  256'(s1_axi.rvalid), 256'(0));
                    end
                    if (m_axi.rlast) void'(route_q.pop_front());
                end
            end
            if (m_axi.arvalid && m_axi.arready) begin
                if (ar_q.size() == 0) check("ar_sb_empty", 256'(1), 256'(0));
                else check("m_ar_addr_len", 256'({m_axi.araddr, m_axi.arlen}), 256'(ar_q.pop_front()));
            end
            if (s0_axi.arready || s1_axi.arready)
                check("ar_onehot", 256'(s0_axi.arready & s1_axi.arready), 256'(0));
            if (s0_axi.arvalid && s0_axi.arready) begin
                ar_q.push_back({s0_axi.araddr, s0_axi.arlen});
                route_q.push_back('{port: 1'b0, id: s0_axi.arid});
            end
            if (s1_axi.arvalid && s1_axi.arready) begin
                ar_q.push_back({s1_axi.araddr, s1_axi.arlen});
                route_q.push_back('{port: 1'b1, id: s1_axi.arid});
            end
        end
    end

    task automatic set_ar(input int p, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                          input logic [LEN_W-1:0] len, input logic [QOS_W-1:0] qos);
        if (p == 0) begin
            s0_axi.araddr = addr; s0_axi.arid = id; s0_axi.arlen = len; s0_axi.arqos = qos;
            s0_axi.arvalid = 1'b1;
        end else begin
            s1_axi.araddr = addr; s1_axi.arid = id; s1_axi.arlen = len; s1_axi.arqos = qos;
            s1_axi.arvalid = 1'b1;
        end
    endtask

    task automatic send_ar(input int p, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                           input logic [LEN_W-1:0] len, input logic [QOS_W-1:0] qos);
        bit got = 0;
        set_ar(p, addr, id, len, qos);
        for (int i = 0; i < 100; i++) begin
            #1;
            if ((p == 0) ? s0_axi.arready : s1_axi.arready) begin got = 1; break; end
            tick();
        end
        if (!got) check("ar_timeout", 256'(0), 256'(1));
        tick();
        if (p == 0) s0_axi.arvalid = 1'b0; else s1_axi.arvalid = 1'b0;
    endtask

    task automatic send_beat(input logic last);
        bit got = 0;
        logic [DATA_W-1:0] d;
        d = next_data();
        rdat_q.push_back(d);
        m_axi.rdata = d; m_axi.rlast = last; m_axi.rvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (m_axi.rready) begin got = 1; break; end
            tick();
        end
        if (!got) check("r_timeout", 256'(0), 256'(1));
        tick();
        m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        ar_q.delete(); route_q.delete(); rdat_q.delete();
        tick(); tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int rx_base;
        bit exp_s1_first;

        s0_axi.araddr = '0; s0_axi.arlen = '0; s0_axi.arsize = 3'd5; s0_axi.arburst = 2'd1;
        s0_axi.arcache = '0; s0_axi.arprot = '0; s0_axi.arqos = '0; s0_axi.arid = '0;
        s0_axi.arvalid = 1'b0; s0_axi.rready = 1'b1;
        s1_axi.araddr = '0; s1_axi.arlen = '0; s1_axi.arsize = 3'd5; s1_axi.arburst = 2'd1;
        s1_axi.arcache = '0; s1_axi.arprot = '0; s1_axi.arqos = '0; s1_axi.arid = '0;
        s1_axi.arvalid = 1'b0; s1_axi.rready = 1'b1;
        m_axi.arready = 1'b1; m_axi.rdata = '0; m_axi.rresp = '0; m_axi.rlast = 1'b0;
        m_axi.rvalid = 1'b1;
        rx_cnt[0] = 0; rx_cnt[1] = 0;

        // Reset state with requests and R traffic present.
        aresetn = 1'b0;
        s0_axi.arvalid = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_m_arvalid",  256'(m_axi.arvalid),  256'(0));
        check("rst_m_araddr",   256'(m_axi.araddr),   256'(0));
        check("rst_s0_arready", 256'(s0_axi.arready), 256'(0));
        check("rst_m_rready",   256'(m_axi.rready),   256'(0));
        check("rst_s0_rvalid",  256'(s0_axi.rvalid),  256'(0));
        s0_axi.arvalid = 1'b0; m_axi.rvalid = 1'b0;
        tick();
        aresetn = 1'b1;

        // Simultaneous requests after reset: port 0 first, then port 1.
        set_ar(0, 33'h0_0000_0100, 3'd1, 8'd0, 4'd0);
        set_ar(1, 33'h0_0000_0200, 3'd2, 8'd0, 4'd0);
        #1;
        check("rr_s0_first",   256'(s0_axi.arready), 256'(1));
        check("rr_s1_waits",   256'(s1_axi.arready), 256'(0));
        tick();
        s0_axi.arvalid = 1'b0;
        #1;
        check("rr_s1_next",    256'(s1_axi.arready), 256'(1));
        check("rr_m_arvalid",  256'(m_axi.arvalid),  256'(1));
        check("rr_m_addr0",    256'(m_axi.araddr),   256'(33'h100));
        tick();
        s1_axi.arvalid = 1'b0;
        #1;
        check("rr_m_addr1",    256'(m_axi.araddr),   256'(33'h200));
        tick();
        send_beat(1'b1);
        send_beat(1'b1);

        // Port 1 burst id=5 len=3, four beats.
        rx_base = rx_cnt[1];
        send_ar(1, 33'h1_0000_0300, 3'd5, 8'd3, 4'd0);
        tick();
        for (int i = 0; i < 4; i++) send_beat(i == 3);
        check("p1_beats", 256'(rx_cnt[1] - rx_base), 256'(4));
        #1;
        check("p1_fifo_empty_rready", 256'(m_axi.rready), 256'(0));
        tick();

        // Backpressure on the shared AR, then fill the route FIFO.
        m_axi.arready = 1'b0;
        set_ar(0, 33'h0_0000_1000, 3'd1, 8'd0, 4'd0);
        #1;
        check("bp_first_gnt", 256'(s0_axi.arready), 256'(1));
        tick();
        s0_axi.arvalid = 1'b0;
        set_ar(1, 33'h0_0000_1100, 3'd2, 8'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_m_arvalid",   256'(m_axi.arvalid),  256'(1));
            check("bp_addr_stable", 256'(m_axi.araddr),   256'(33'h1000));
            check("bp_s1_blocked",  256'(s1_axi.arready), 256'(0));
            tick();
        end
        m_axi.arready = 1'b1;
        #1;
        check("bp_release", 256'(s1_axi.arready), 256'(1));
        tick();
        s1_axi.arvalid = 1'b0;
        for (int i = 2; i < 8; i++)
            send_ar(i % 2, 33'(32'h1000 + 32'(i) * 32'h100), 3'(i), 8'd0, 4'd0);
        tick();

        // Ninth request while full; a last-beat pop does not pass it through.
        set_ar(0, 33'h0_0000_1800, 3'd0, 8'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_block", 256'(s0_axi.arready), 256'(0));
            tick();
        end
        d = next_data();
        rdat_q.push_back(d);
        m_axi.rdata = d; m_axi.rlast = 1'b1; m_axi.rvalid = 1'b1;
        #1;
        check("full_pop_rready",  256'(m_axi.rready),  256'(1));
        check("full_no_passthru", 256'(s0_axi.arready), 256'(0));
        tick();
        m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
        #1;
        check("full_unblock", 256'(s0_axi.arready), 256'(1));
        tick();
        s0_axi.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(1'b1);

        // Grant and final-beat pop together at count 3.
        set_ar(1, 33'h0_0000_1900, 3'd6, 8'd0, 4'd0);
        d = next_data();
        rdat_q.push_back(d);
        m_axi.rdata = d; m_axi.rlast = 1'b1; m_axi.rvalid = 1'b1;
        #1;
        check("sim_pre_count",   256'(dut.u_fifo.count), 256'(3));
        check("sim_gnt",         256'(s1_axi.arready),   256'(1));
        check("sim_pop_rready",  256'(m_axi.rready),     256'(1));
        tick();
        s1_axi.arvalid = 1'b0; m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
        #1;
        check("sim_count",       256'(dut.u_fifo.count), 256'(3));
        check("sim_head_rid",    256'(s1_axi.rid),       256'(7));
        tick();
        for (int i = 0; i < 3; i++) send_beat(1'b1);
        #1;
        check("drain_empty_rready", 256'(m_axi.rready), 256'(0));
        tick();

        // Port 0 stalls mid-burst; beats held, order kept.
        rx_base = rx_cnt[0];
        send_ar(0, 33'h0_0000_2000, 3'd2, 8'd3, 4'd0);
        tick();
        send_beat(1'b0);
        d = next_data();
        rdat_q.push_back(d);
        m_axi.rdata = d; m_axi.rlast = 1'b0; m_axi.rvalid = 1'b1;
        s0_axi.rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_m_rready", 256'(m_axi.rready),  256'(0));
            check("stall_s0_rvalid", 256'(s0_axi.rvalid), 256'(1));
            check("stall_s0_rdata", s0_axi.rdata,         d);
            tick();
        end
        s0_axi.rready = 1'b1;
        #1;
        check("stall_release", 256'(m_axi.rready), 256'(1));
        tick();
        m_axi.rvalid = 1'b0;
        send_beat(1'b0);
        send_beat(1'b1);
        check("stall_beats", 256'(rx_cnt[0] - rx_base), 256'(4));

        // QoS: port 1 arqos=4 vs port 0 arqos=1, fresh round-robin state.
        do_reset();
`ifdef M00_RD_ARB_QOS_EN
        exp_s1_first = 1'b1;
`else
        exp_s1_first = 1'b0;
`endif
        set_ar(0, 33'h0_0000_3000, 3'd3, 8'd0, 4'd1);
        set_ar(1, 33'h0_0000_3100, 3'd4, 8'd0, 4'd4);
        #1;
        check("qos_s0_arready", 256'(s0_axi.arready), 256'(!exp_s1_first));
        check("qos_s1_arready", 256'(s1_axi.arready), 256'(exp_s1_first));
        tick();
        if (exp_s1_first) s1_axi.arvalid = 1'b0; else s0_axi.arvalid = 1'b0;
        #1;
        check("qos_second", 256'(exp_s1_first ? s0_axi.arready : s1_axi.arready), 256'(1));
        tick();
        s0_axi.arvalid = 1'b0; s1_axi.arvalid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
